// File: rtl/credit_pkg.sv
// Shared types and defaults for the transmit-side credit tracker.
package credit_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } credit_state_e;

  localparam int DEF_MAX_CREDITS = 3;
  localparam int DEF_CW          = 3;

endpackage

// File: rtl/sat_updown_counter.sv
// Up/down counter that resets to MAX and saturates at 0 and MAX.
// ovf_o pulses when an increment is dropped because the count is already MAX.
module sat_updown_counter #(
  parameter int MAX = 3,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          ovf_o
);

  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] count_q, count_d;

  // Simultaneous inc and dec cancel; each direction clamps at its bound.
  always_comb begin
    count_d = count_q;
    ovf_o   = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q == MAX_V) ovf_o   = 1'b1;
      else                  count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (count_q != '0)    count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) count_q <= MAX_V;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/credit_down_counter.sv
// Transmit credit tracker: spends a credit per accepted send, regains one per return,
// and drains on request. Optional sticky over-return flag under `CREDIT_ERR_EN.
//
// Handshake: a send transfers (fire) on a clock edge where send_valid_i and
// send_ready_o are both high; send_ready_o depends only on registered state.
module credit_down_counter
  import credit_pkg::*;
#(
  parameter int MAX_CREDITS = DEF_MAX_CREDITS,
  parameter int CW          = DEF_CW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          send_valid_i,
  output logic          send_ready_o,
  input  logic          ret_valid_i,
  input  logic          flush_req_i,
  output logic          flush_done_o,
  output logic [CW-1:0] credits_o,
`ifdef CREDIT_ERR_EN
  output logic          err_ovf_o,
`endif
  output credit_state_e state_o
);

  localparam logic [CW-1:0] MAX_V = CW'(MAX_CREDITS);

  credit_state_e state_q, state_d;
  logic          flush_done_q, flush_done_d;
  logic          fire;
  logic          ovf;
  logic [CW-1:0] credits;

  assign send_ready_o = (credits != '0) && (state_q == ST_RUN);
  assign fire         = send_valid_i && send_ready_o;

  sat_updown_counter #(
    .MAX (MAX_CREDITS),
    .CW  (CW)
  ) u_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .inc_i   (ret_valid_i),
    .dec_i   (fire),
    .count_o (credits),
    .ovf_o   (ovf)
  );

  // Dropping flush_req while draining aborts back to RUN without signalling done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (flush_req_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!flush_req_i)          state_d = ST_RUN;
        else if (credits == MAX_V) state_d = ST_DONE;
      end
      ST_DONE:  if (!flush_req_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    flush_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_RUN;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign flush_done_o = flush_done_q;
  assign credits_o    = credits;
  assign state_o      = state_q;

`ifdef CREDIT_ERR_EN
  logic err_ovf_q;

  always_ff @(posedge clk) begin
    if (!resetn)  err_ovf_q <= 1'b0;
    else if (ovf) err_ovf_q <= 1'b1;
  end

  assign err_ovf_o = err_ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

endmodule

// File: tb/tb_credit_down_counter.sv
// Bench for credit_down_counter: vector table, hand sequences and a random phase
// checked against a behavioural model; err_ovf is checked when CREDIT_ERR_EN is defined.
module tb_credit_down_counter;
  import credit_pkg::*;

  localparam int CW = 3;
  localparam int W  = CW + 5;
  localparam logic [CW-1:0] MAXC = 3'd3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          send_valid;
  logic          send_ready;
  logic          ret_valid;
  logic          flush_req;
  logic          flush_done;
  logic [CW-1:0] credits;
  logic          err_ovf;
  credit_state_e state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic          sv, rv, fr, rn;
    logic [CW-1:0] e_cred;
    logic          e_rdy, e_done, e_err;
    credit_state_e e_st;
  } vec_t;
  vec_t vecs[$];

  // Behavioural model for the random phase
  logic [CW-1:0] m_c;
  credit_state_e m_s;
  logic          m_e;

  credit_down_counter #(.MAX_CREDITS(3), .CW(CW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .send_valid_i (send_valid),
    .send_ready_o (send_ready),
    .ret_valid_i  (ret_valid),
    .flush_req_i  (flush_req),
    .flush_done_o (flush_done),
    .credits_o    (credits),
`ifdef CREDIT_ERR_EN
    .err_ovf_o    (err_ovf),
`endif
    .state_o      (state)
  );

`ifndef CREDIT_ERR_EN
  assign err_ovf = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input credit_state_e st, input logic e,
                                        input logic d, input logic r, input logic [CW-1:0] c);
    return {st, e, d, r, c};
  endfunction

  task automatic compare_out();
    logic [W-1:0]  e;
    credit_state_e e_st;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
      return;
    end
    e    = exp_q.pop_front();
    e_st = credit_state_e'(e[W-1 -: 2]);
    check("credits",    int'(credits),    int'(e[CW-1:0]));
    check("send_ready", int'(send_ready), int'(e[CW]));
    check("flush_done", int'(flush_done), int'(e[CW+1]));
    check("state",      int'(state),      int'(e_st));
`ifdef CREDIT_ERR_EN
    check("err_ovf",    int'(err_ovf),    int'(e[CW+2]));
`endif
  endtask

  // driver: apply inputs for one edge, push the expectation, check after the edge
  task automatic step(input logic sv, input logic rv, input logic fr, input logic rn,
                      input logic [W-1:0] exp);
    @(negedge clk);
    send_valid = sv;
    ret_valid  = rv;
    flush_req  = fr;
    resetn     = rn;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic add(input logic sv, rv, fr, rn, input logic [CW-1:0] c,
                     input logic r, d, e, input credit_state_e st);
    vec_t v;
    v.sv = sv; v.rv = rv; v.fr = fr; v.rn = rn;
    v.e_cred = c; v.e_rdy = r; v.e_done = d; v.e_err = e; v.e_st = st;
    vecs.push_back(v);
  endtask

  task automatic model_step(input logic sv, rv, fr, rn);
    logic rdy, fire;
    rdy  = (m_c != 0) && (m_s == ST_RUN);
    fire = sv && rdy;
    if (!rn) begin
      m_c = MAXC; m_s = ST_RUN; m_e = 1'b0;
    end else begin
      case (m_s)
        ST_RUN:   if (fr) m_s = ST_DRAIN;
        ST_DRAIN: if (!fr) m_s = ST_RUN; else if (m_c == MAXC) m_s = ST_DONE;
        default:  if (!fr) m_s = ST_RUN;
      endcase
      if (fire && !rv)               m_c = m_c - 1'b1;
      else if (rv && !fire) begin
        if (m_c == MAXC) m_e = 1'b1;
        else             m_c = m_c + 1'b1;
      end
    end
  endtask

  initial begin
    send_valid = 1'b0; ret_valid = 1'b0; flush_req = 1'b0; resetn = 1'b0;

    //   sv rv fr rn cred rdy done err state
    add(0, 0, 0, 0, 3, 1, 0, 0, ST_RUN);    // reset
    add(1, 0, 0, 1, 2, 1, 0, 0, ST_RUN);
    add(1, 0, 0, 1, 1, 1, 0, 0, ST_RUN);
    add(1, 0, 0, 1, 0, 0, 0, 0, ST_RUN);
    add(1, 0, 0, 1, 0, 0, 0, 0, ST_RUN);    // empty: no fire
    add(0, 1, 0, 1, 1, 1, 0, 0, ST_RUN);
    add(1, 1, 0, 1, 1, 1, 0, 0, ST_RUN);    // fire + return cancel
    add(0, 1, 0, 1, 2, 1, 0, 0, ST_RUN);
    add(0, 1, 0, 1, 3, 1, 0, 0, ST_RUN);
    add(0, 1, 0, 1, 3, 1, 0, 1, ST_RUN);    // over-return ignored
    add(0, 0, 0, 1, 3, 1, 0, 1, ST_RUN);
    add(1, 0, 0, 1, 2, 1, 0, 1, ST_RUN);
    add(1, 0, 0, 1, 1, 1, 0, 1, ST_RUN);
    add(0, 0, 1, 1, 1, 0, 0, 1, ST_DRAIN);
    add(1, 0, 1, 1, 1, 0, 0, 1, ST_DRAIN);  // send blocked while draining
    add(0, 1, 1, 1, 2, 0, 0, 1, ST_DRAIN);
    add(0, 1, 1, 1, 3, 0, 0, 1, ST_DRAIN);
    add(0, 0, 1, 1, 3, 0, 1, 1, ST_DONE);
    add(0, 0, 1, 1, 3, 0, 1, 1, ST_DONE);   // done held
    add(0, 0, 0, 1, 3, 1, 0, 1, ST_RUN);
    add(1, 0, 1, 1, 2, 0, 0, 1, ST_DRAIN);  // fire on flush edge still counts
    add(0, 0, 0, 1, 2, 1, 0, 1, ST_RUN);    // abort drain
    add(1, 0, 0, 1, 1, 1, 0, 1, ST_RUN);
    add(0, 0, 1, 1, 1, 0, 0, 1, ST_DRAIN);
    add(0, 1, 1, 0, 3, 1, 0, 0, ST_RUN);    // reset mid-drain, return lost
    add(0, 0, 0, 1, 3, 1, 0, 0, ST_RUN);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].sv, vecs[i].rv, vecs[i].fr, vecs[i].rn,
           pack(vecs[i].e_st, vecs[i].e_err, vecs[i].e_done, vecs[i].e_rdy, vecs[i].e_cred));

    // flush at full credits reaches DONE one cycle after entering DRAIN
    step(0, 0, 1, 1, pack(ST_DRAIN, 1'b0, 1'b0, 1'b0, 3'd3));
    step(0, 0, 1, 1, pack(ST_DONE,  1'b0, 1'b1, 1'b0, 3'd3));
    step(0, 0, 0, 1, pack(ST_RUN,   1'b0, 1'b0, 1'b1, 3'd3));

    // sticky error survives a flush round-trip at full count
    step(0, 1, 0, 1, pack(ST_RUN, 1'b1, 1'b0, 1'b1, 3'd3));
    step(0, 0, 1, 1, pack(ST_DRAIN, 1'b1, 1'b0, 1'b0, 3'd3));
    step(0, 0, 0, 1, pack(ST_RUN, 1'b1, 1'b0, 1'b1, 3'd3));

    // random traffic against the model, starting from reset
    m_c = MAXC; m_s = ST_RUN; m_e = 1'b0;
    model_step(0, 0, 0, 0);
    step(0, 0, 0, 0, pack(m_s, m_e, (m_s == ST_DONE), (m_c != 0) && (m_s == ST_RUN), m_c));
    for (int i = 0; i < 300; i++) begin
      logic sv, rv, fr, rn;
      sv = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) == 0);
      fr = (i % 40) >= 25;
      rn = ($urandom_range(0, 49) != 0);
      model_step(sv, rv, fr, rn);
      step(sv, rv, fr, rn,
           pack(m_s, m_e, (m_s == ST_DONE), (m_c != 0) && (m_s == ST_RUN), m_c));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
